// File: rtl/uart_rx_multi.sv
// uart_rx_multi
//   Parametrised UART receiver: configurable data width, parity mode and stop-bit count.
//   Every bit is taken as the 3-point majority of rx_s around the bit centre. Each frame
//   that survives the start-bit check produces one data_valid pulse with data and
//   parity/framing/break status. A one-shot block_timeout marks the end of a burst of frames.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per bit (>= 4)
//   DATA_BITS     data bits per frame (5..9)
//   PARITY        0 none, 1 even, 2 odd
//   STOP_BITS     1 or 2
//   TIMEOUT_BITS  idle bit-times after the last frame before block_timeout fires
//
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   rx             asynchronous serial input, idle high
//   rx_bsy         high from start-edge detection until the frame ends or is rejected
//   data_valid     one-cycle pulse: data_out and the error flags are valid
//   data_out       received word, LSB first on the line
//   parity_err     parity mismatch for the frame flagged by data_valid
//   frame_err      any stop bit sampled low
//   break_det      data all zero, parity (if any) zero, first stop bit low
//   block_timeout  one-cycle pulse once the line has been idle long enough after a frame
module uart_rx_multi #(
   parameter int unsigned CLKS_PER_BIT = 27,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned TIMEOUT_BITS = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic                 rx_bsy,
   output logic                 data_valid,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 block_timeout
);

   localparam int unsigned CntW          = $clog2(CLKS_PER_BIT);
   localparam int unsigned IdxW          = $clog2(DATA_BITS);
   localparam int unsigned Half          = CLKS_PER_BIT / 2;
   localparam int unsigned TimeoutCycles = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int unsigned IdleW         = $clog2(TimeoutCycles + 1);

   localparam logic [CntW-1:0]  CntSampA = CntW'(Half - 1);
   localparam logic [CntW-1:0]  CntSampB = CntW'(Half);
   localparam logic [CntW-1:0]  CntDec   = CntW'(Half + 1);
   localparam logic [CntW-1:0]  CntLast  = CntW'(CLKS_PER_BIT - 1);
   localparam logic [IdxW-1:0]  IdxLast  = IdxW'(DATA_BITS - 1);
   localparam logic [IdleW-1:0] IdleLast = IdleW'(TimeoutCycles - 1);
   localparam logic             StopLast = 1'(STOP_BITS - 1);
   localparam logic             ParOdd   = (PARITY == 2);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StWaitHigh
   } state_e;

   state_e               state_q, state_d;
   logic                 sync1_q, rx_s_q, rx_prev_q;
   logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
   logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
   logic                 stop_idx_q, stop_idx_d;
   logic [1:0]           samp_q, samp_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_bit_q, par_bit_d;
   logic                 stop0_q, stop0_d;
   logic                 ferr_acc_q, ferr_acc_d;
   logic                 armed_q, armed_d;
   logic [IdleW-1:0]     idle_cnt_q, idle_cnt_d;

   logic                 rx_bsy_q, rx_bsy_d;
   logic                 data_valid_q, data_valid_d;
   logic [DATA_BITS-1:0] data_out_q, data_out_d;
   logic                 parity_err_q, parity_err_d;
   logic                 frame_err_q, frame_err_d;
   logic                 break_det_q, break_det_d;
   logic                 block_timeout_q, block_timeout_d;

   logic fall;
   logic maj;
   logic at_dec;
   logic at_end;
   logic first_stop;

   // Falling edge of the synchronized line.
   assign fall = rx_prev_q & ~rx_s_q;

   // Third vote is the live rx_s in the decision cycle.
   assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

   assign at_dec     = (bit_cnt_q == CntDec);
   assign at_end     = (bit_cnt_q == CntLast);
   assign first_stop = (stop_idx_q == 1'b0) ? maj : stop0_q;

   always_comb begin
      state_d         = state_q;
      bit_cnt_d       = bit_cnt_q;
      bit_idx_d       = bit_idx_q;
      stop_idx_d      = stop_idx_q;
      samp_d          = samp_q;
      shift_d         = shift_q;
      par_bit_d       = par_bit_q;
      stop0_d         = stop0_q;
      ferr_acc_d      = ferr_acc_q;
      armed_d         = armed_q;
      idle_cnt_d      = idle_cnt_q;
      rx_bsy_d        = rx_bsy_q;
      data_valid_d    = 1'b0;
      data_out_d      = data_out_q;
      parity_err_d    = parity_err_q;
      frame_err_d     = frame_err_q;
      break_det_d     = break_det_q;
      block_timeout_d = 1'b0;

      if (bit_cnt_q == CntSampA) begin
         samp_d[0] = rx_s_q;
      end
      if (bit_cnt_q == CntSampB) begin
         samp_d[1] = rx_s_q;
      end

      // Bit-period counter free-runs while a frame is in flight.
      if (state_q != StIdle && state_q != StWaitHigh) begin
         bit_cnt_d = at_end ? '0 : bit_cnt_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (fall) begin
               state_d   = StStart;
               bit_cnt_d = '0;
               rx_bsy_d  = 1'b1;
            end
         end

         StStart: begin
            if (at_dec && maj) begin
               // False start: line back high at the centre of the start bit.
               state_d   = StIdle;
               bit_cnt_d = '0;
               rx_bsy_d  = 1'b0;
            end else if (at_end) begin
               state_d   = StData;
               bit_idx_d = '0;
            end
         end

         StData: begin
            if (at_dec) begin
               shift_d = {maj, shift_q[DATA_BITS-1:1]};
            end
            if (at_end) begin
               if (bit_idx_q == IdxLast) begin
                  bit_idx_d  = '0;
                  stop_idx_d = 1'b0;
                  ferr_acc_d = 1'b0;
                  state_d    = (PARITY != 0) ? StParity : StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end

         StParity: begin
            if (at_dec) begin
               par_bit_d = maj;
            end
            if (at_end) begin
               state_d = StStop;
            end
         end

         StStop: begin
            if (at_dec) begin
               if (stop_idx_q == 1'b0) begin
                  stop0_d = maj;
               end
               if (stop_idx_q == StopLast) begin
                  data_valid_d = 1'b1;
                  data_out_d   = shift_q;
                  parity_err_d = (PARITY != 0) && ((^shift_q ^ par_bit_q) != ParOdd);
                  frame_err_d  = ferr_acc_q | ~maj;
                  break_det_d  = (shift_q == '0) && ((PARITY == 0) || !par_bit_q) && !first_stop;
                  rx_bsy_d     = 1'b0;
                  armed_d      = 1'b1;
                  bit_cnt_d    = '0;
                  // A low last stop bit means the line may be held in break; wait it out.
                  state_d      = maj ? StIdle : StWaitHigh;
               end else begin
                  ferr_acc_d = ferr_acc_q | ~maj;
               end
            end
            if (at_end && (stop_idx_q != StopLast)) begin
               stop_idx_d = 1'b1;
            end
         end

         StWaitHigh: begin
            if (rx_s_q) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // Idle timer only runs while armed; one pulse per burst.
      if (state_q == StIdle && armed_q && !fall) begin
         if (idle_cnt_q == IdleLast) begin
            block_timeout_d = 1'b1;
            armed_d         = 1'b0;
            idle_cnt_d      = '0;
         end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
         end
      end else begin
         idle_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q         <= 1'b1;
         rx_s_q          <= 1'b1;
         rx_prev_q       <= 1'b1;
         state_q         <= StIdle;
         bit_cnt_q       <= '0;
         bit_idx_q       <= '0;
         stop_idx_q      <= 1'b0;
         samp_q          <= '0;
         shift_q         <= '0;
         par_bit_q       <= 1'b0;
         stop0_q         <= 1'b0;
         ferr_acc_q      <= 1'b0;
         armed_q         <= 1'b0;
         idle_cnt_q      <= '0;
         rx_bsy_q        <= 1'b0;
         data_valid_q    <= 1'b0;
         data_out_q      <= '0;
         parity_err_q    <= 1'b0;
         frame_err_q     <= 1'b0;
         break_det_q     <= 1'b0;
         block_timeout_q <= 1'b0;
      end else begin
         sync1_q         <= rx;
         rx_s_q          <= sync1_q;
         rx_prev_q       <= rx_s_q;
         state_q         <= state_d;
         bit_cnt_q       <= bit_cnt_d;
         bit_idx_q       <= bit_idx_d;
         stop_idx_q      <= stop_idx_d;
         samp_q          <= samp_d;
         shift_q         <= shift_d;
         par_bit_q       <= par_bit_d;
         stop0_q         <= stop0_d;
         ferr_acc_q      <= ferr_acc_d;
         armed_q         <= armed_d;
         idle_cnt_q      <= idle_cnt_d;
         rx_bsy_q        <= rx_bsy_d;
         data_valid_q    <= data_valid_d;
         data_out_q      <= data_out_d;
         parity_err_q    <= parity_err_d;
         frame_err_q     <= frame_err_d;
         break_det_q     <= break_det_d;
         block_timeout_q <= block_timeout_d;
      end
   end

   assign rx_bsy        = rx_bsy_q;
   assign data_valid    = data_valid_q;
   assign data_out      = data_out_q;
   assign parity_err    = parity_err_q;
   assign frame_err     = frame_err_q;
   assign break_det     = break_det_q;
   assign block_timeout = block_timeout_q;

endmodule

// File: tb/tb_uart_rx_multi.sv
// Bench for uart_rx_multi: three instances (8N1, 8E1, 7O2 at 16 clk/bit) driven with directed
// and random frames; expectations come from a frame-level model of the line protocol.
module tb_uart_rx_multi;

   localparam int unsigned CpbA = 27;
   localparam int unsigned CpbC = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b, rst_c;
   logic rx_a, rx_b, rx_c;
   logic bsy_a, dv_a, pe_a, fe_a, bk_a, bt_a;
   logic bsy_b, dv_b, pe_b, fe_b, bk_b, bt_b;
   logic bsy_c, dv_c, pe_c, fe_c, bk_c, bt_c;
   logic [7:0] do_a, do_b;
   logic [6:0] do_c;

   uart_rx_multi #(.CLKS_PER_BIT(CpbA), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                   .TIMEOUT_BITS(2)) u_dut_a (
      .clk(clk), .rst(rst_a), .rx(rx_a), .rx_bsy(bsy_a), .data_valid(dv_a), .data_out(do_a),
      .parity_err(pe_a), .frame_err(fe_a), .break_det(bk_a), .block_timeout(bt_a));

   uart_rx_multi #(.CLKS_PER_BIT(CpbA), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                   .TIMEOUT_BITS(2)) u_dut_b (
      .clk(clk), .rst(rst_b), .rx(rx_b), .rx_bsy(bsy_b), .data_valid(dv_b), .data_out(do_b),
      .parity_err(pe_b), .frame_err(fe_b), .break_det(bk_b), .block_timeout(bt_b));

   uart_rx_multi #(.CLKS_PER_BIT(CpbC), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
                   .TIMEOUT_BITS(2)) u_dut_c (
      .clk(clk), .rst(rst_c), .rx(rx_c), .rx_bsy(bsy_c), .data_valid(dv_c), .data_out(do_c),
      .parity_err(pe_c), .frame_err(fe_c), .break_det(bk_c), .block_timeout(bt_c));

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Event log per instance, sampled on the falling clock edge.
   int         dv_cnt   [3] = '{default: 0};
   int         dv_cyc   [3] = '{default: 0};
   int         bt_cnt   [3] = '{default: 0};
   int         bt_cyc   [3] = '{default: 0};
   int         bsy_rise [3] = '{default: 0};
   int         start_cyc[3] = '{default: 0};
   logic [8:0] cap_data [3] = '{default: '0};
   logic       cap_pe   [3] = '{default: 1'b0};
   logic       cap_fe   [3] = '{default: 1'b0};
   logic       cap_bk   [3] = '{default: 1'b0};
   logic       bsy_prev [3] = '{default: 1'b0};

   task automatic mon(input int k, input logic dv, input logic [8:0] d, input logic pe,
                      input logic fe, input logic bk, input logic bt, input logic bsy);
      if (dv) begin
         dv_cnt[k]++;
         dv_cyc[k]   = cyc;
         cap_data[k] = d;
         cap_pe[k]   = pe;
         cap_fe[k]   = fe;
         cap_bk[k]   = bk;
      end
      if (bt) begin
         bt_cnt[k]++;
         bt_cyc[k] = cyc;
      end
      if (bsy && !bsy_prev[k]) bsy_rise[k]++;
      bsy_prev[k] = bsy;
   endtask

   always @(negedge clk) begin
      mon(0, dv_a, {1'b0, do_a}, pe_a, fe_a, bk_a, bt_a, bsy_a);
      mon(1, dv_b, {1'b0, do_b}, pe_b, fe_b, bk_b, bt_b, bsy_b);
      mon(2, dv_c, {2'b00, do_c}, pe_c, fe_c, bk_c, bt_c, bsy_c);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int cpb_of(input int k);
      return (k == 2) ? CpbC : CpbA;
   endfunction

   task automatic set_rx(input int k, input logic v);
      case (k)
         0:       rx_a = v;
         1:       rx_b = v;
         default: rx_c = v;
      endcase
   endtask

   task automatic idle(input int k, input int nbits);
      set_rx(k, 1'b1);
      tick(nbits * cpb_of(k));
   endtask

   // Drives one frame onto the pin; the line is left at the last stop-bit level.
   task automatic send_frame(input int k, input logic [8:0] d, input int nd, input int pm,
                             input logic p, input logic s0, input logic s1, input int ns);
      int c;
      c = cpb_of(k);
      start_cyc[k] = cyc;
      set_rx(k, 1'b0);
      tick(c);
      for (int i = 0; i < nd; i++) begin
         set_rx(k, d[i]);
         tick(c);
      end
      if (pm != 0) begin
         set_rx(k, p);
         tick(c);
      end
      set_rx(k, s0);
      tick(c);
      if (ns == 2) begin
         set_rx(k, s1);
         tick(c);
      end
   endtask

   // Frame-level reference: {parity_err, frame_err, break_det}.
   function automatic logic [2:0] model(input logic [8:0] d, input int nd, input int pm,
                                        input logic p, input logic s0, input logic s1,
                                        input int ns);
      int ones;
      int zero_data;
      logic pe, fe, bk;
      ones      = 0;
      zero_data = 1;
      for (int i = 0; i < nd; i++) begin
         ones += int'(d[i]);
         if (d[i]) zero_data = 0;
      end
      ones += (pm != 0) ? int'(p) : 0;
      pe = (pm == 1) ? ((ones % 2) == 1) : (pm == 2) ? ((ones % 2) == 0) : 1'b0;
      fe = !s0 || ((ns == 2) && !s1);
      bk = (zero_data == 1) && ((pm == 0) || !p) && !s0;
      return {pe, fe, bk};
   endfunction

   task automatic check_frame(input string tag, input int k, input int prev_dv,
                              input logic [8:0] d, input int nd, input int pm, input logic p,
                              input logic s0, input logic s1, input int ns);
      logic [2:0] e;
      logic [8:0] mask;
      int nb, lat_exp, diff;
      e       = model(d, nd, pm, p, s0, s1, ns);
      mask    = 9'((1 << nd) - 1);
      nb      = 1 + nd + ((pm != 0) ? 1 : 0) + ns;
      lat_exp = ((2 * nb - 1) * cpb_of(k)) / 2 + 4;
      diff    = dv_cyc[k] - start_cyc[k] - lat_exp;
      chk({tag, "_dv"},   dv_cnt[k], prev_dv + 1);
      chk({tag, "_data"}, cap_data[k], d & mask);
      chk({tag, "_pe"},   cap_pe[k], e[2]);
      chk({tag, "_fe"},   cap_fe[k], e[1]);
      chk({tag, "_bk"},   cap_bk[k], e[0]);
      chk({tag, "_lat"},  (diff >= -2 && diff <= 2), 1);
   endtask

   initial begin
      int prev, prev_bt, prev_bsy;
      logic [8:0] d;
      logic p, s0, s1;

      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      rx_a  = 1'b1; rx_b  = 1'b1; rx_c  = 1'b1;
      tick(3);
      chk("rst_dv_a",   dv_a, 0);
      chk("rst_data_a", do_a, 0);
      chk("rst_bsy_a",  bsy_a, 0);
      chk("rst_flags_a", {pe_a, fe_a, bk_a, bt_a}, 0);
      chk("rst_data_c", do_c, 0);
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

      // No timeout pulse before any frame.
      tick(200);
      chk("no_bt_after_rst", bt_cnt[0], 0);

      // 8N1 0xA5.
      prev = dv_cnt[0];
      send_frame(0, 9'hA5, 8, 0, 1'b0, 1'b1, 1'b1, 1);
      tick(4);
      check_frame("a5", 0, prev, 9'hA5, 8, 0, 1'b0, 1'b1, 1'b1, 1);
      chk("a5_bsy_low", bsy_a, 0);
      idle(0, 10);

      // Short low glitch: false start.
      prev     = dv_cnt[0];
      prev_bsy = bsy_rise[0];
      set_rx(0, 1'b0);
      tick(5);
      idle(0, 3);
      chk("glitch_bsy_pulse", bsy_rise[0], prev_bsy + 1);
      chk("glitch_no_dv", dv_cnt[0], prev);
      chk("glitch_data_held", do_a, 8'hA5);
      chk("glitch_bsy_low", bsy_a, 0);
      idle(0, 4);

      // Break: all zero, stop low, line held low for 40 bit-times.
      prev = dv_cnt[0];
      send_frame(0, 9'h000, 8, 0, 1'b0, 1'b0, 1'b0, 1);
      tick(40 * CpbA);
      check_frame("brk", 0, prev, 9'h000, 8, 0, 1'b0, 1'b0, 1'b0, 1);
      chk("brk_bsy_low", bsy_a, 0);
      idle(0, 3);
      chk("brk_no_second_dv", dv_cnt[0], prev + 1);
      send_frame(0, 9'h05A, 8, 0, 1'b0, 1'b1, 1'b1, 1);
      tick(4);
      check_frame("after_brk", 0, prev + 1, 9'h05A, 8, 0, 1'b0, 1'b1, 1'b1, 1);
      idle(0, 10);

      // Back-to-back 0x11, 0x22 then idle: exactly one timeout, TIMEOUT_BITS*CPB after the
      // second frame's completion.
      prev    = dv_cnt[0];
      prev_bt = bt_cnt[0];
      send_frame(0, 9'h011, 8, 0, 1'b0, 1'b1, 1'b1, 1);
      send_frame(0, 9'h022, 8, 0, 1'b0, 1'b1, 1'b1, 1);
      tick(4);
      check_frame("b2b", 0, prev + 1, 9'h022, 8, 0, 1'b0, 1'b1, 1'b1, 1);
      idle(0, 20);
      chk("b2b_bt_once", bt_cnt[0], prev_bt + 1);
      chk("b2b_bt_delay", bt_cyc[0] - dv_cyc[0], 2 * CpbA);

      // Random 8N1 frames, occasional low stop bit.
      for (int i = 0; i < 6; i++) begin
         d    = 9'($urandom_range(0, 255));
         s0   = ($urandom_range(0, 3) != 0);
         prev = dv_cnt[0];
         send_frame(0, d, 8, 0, 1'b0, s0, 1'b1, 1);
         tick(4);
         check_frame("rnd_a", 0, prev, d, 8, 0, 1'b0, s0, 1'b1, 1);
         idle(0, 3);
      end

      // Even parity.
      prev = dv_cnt[1];
      send_frame(1, 9'h03C, 8, 1, 1'b0, 1'b1, 1'b1, 1);
      tick(4);
      check_frame("even_ok", 1, prev, 9'h03C, 8, 1, 1'b0, 1'b1, 1'b1, 1);
      idle(1, 3);
      prev = dv_cnt[1];
      send_frame(1, 9'h03C, 8, 1, 1'b1, 1'b1, 1'b1, 1);
      tick(4);
      check_frame("even_bad", 1, prev, 9'h03C, 8, 1, 1'b1, 1'b1, 1'b1, 1);
      idle(1, 3);
      for (int i = 0; i < 6; i++) begin
         d    = 9'($urandom_range(0, 255));
         p    = 1'($urandom_range(0, 1));
         s0   = ($urandom_range(0, 3) != 0);
         prev = dv_cnt[1];
         send_frame(1, d, 8, 1, p, s0, 1'b1, 1);
         tick(4);
         check_frame("rnd_b", 1, prev, d, 8, 1, p, s0, 1'b1, 1);
         idle(1, 3);
      end

      // 7O2 random frames.
      for (int i = 0; i < 6; i++) begin
         d    = 9'($urandom_range(0, 127));
         p    = 1'($urandom_range(0, 1));
         s0   = ($urandom_range(0, 3) != 0);
         s1   = ($urandom_range(0, 3) != 0);
         prev = dv_cnt[2];
         send_frame(2, d, 7, 2, p, s0, s1, 2);
         tick(4);
         check_frame("rnd_c", 2, prev, d, 7, 2, p, s0, s1, 2);
         idle(2, 3);
      end

      // Reset in the middle of bit 3, directly after a good frame.
      prev = dv_cnt[2];
      send_frame(2, 9'h02A, 7, 2, 1'b0, 1'b1, 1'b1, 2);
      tick(4);
      check_frame("pre_rst", 2, prev, 9'h02A, 7, 2, 1'b0, 1'b1, 1'b1, 2);
      prev    = dv_cnt[2];
      prev_bt = bt_cnt[2];
      set_rx(2, 1'b0); tick(CpbC);
      set_rx(2, 1'b1); tick(CpbC);
      set_rx(2, 1'b0); tick(CpbC);
      set_rx(2, 1'b1); tick(CpbC);
      set_rx(2, 1'b0); tick(CpbC / 2);
      rst_c = 1'b1;
      set_rx(2, 1'b1);
      tick(1);
      rst_c = 1'b0;
      chk("rst_mid_bsy",   bsy_c, 0);
      chk("rst_mid_data",  do_c, 0);
      chk("rst_mid_flags", {dv_c, pe_c, fe_c, bk_c, bt_c}, 0);
      idle(2, 20);
      chk("rst_mid_no_dv", dv_cnt[2], prev);
      chk("rst_mid_no_bt", bt_cnt[2], prev_bt);
      send_frame(2, 9'h055, 7, 2, 1'b1, 1'b1, 1'b1, 2);
      tick(4);
      check_frame("post_rst", 2, prev, 9'h055, 7, 2, 1'b1, 1'b1, 1'b1, 2);
      idle(2, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
